snd_cmd_latch: RTL and testbench
================================

SND_CMD_LATCH -- requirements
Module: snd_cmd_latch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter NMI_GAP, default 16, meaning the number of SCPU_CE ticks NMI stays low after each pop.
REQ-003 SHALL have port CLK48M  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port MCPU_CE  in  1  main-CPU clock-enable (one CLK48M cycle per main CPU clock).
REQ-006 SHALL have port SNDRQ  in  1  main-CPU sound-port write strobe (level, held across the I/O write).
REQ-007 SHALL have port CPUDO  in  8  main-CPU write data.
REQ-008 SHALL have port SCPU_CE  in  1  sound-CPU clock-enable.
REQ-009 SHALL have port SCPU_RDCS  in  1  sound-CPU read strobe of the command latch address (level).
REQ-010 SHALL have port SCPU_DI  out  8  command byte presented to the sound CPU.
REQ-011 SHALL have port SNDNMI  out  1  NMI request to the sound CPU, active-high.
REQ-012 SHALL have port OVF  out  1  sticky overflow flag.
REQ-013 SHALL have port CNT  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL sample SNDRQ only on MCPU_CE cycles and push CPUDO once per 0->1 transition of the sampled SNDRQ, however long SNDRQ stays high.
REQ-015 SHALL sample SCPU_RDCS only on SCPU_CE cycles and pop once per 1->0 transition of the sampled SCPU_RDCS; SCPU_DI holds stable while SCPU_RDCS is high.
REQ-016 SHALL drive SCPU_DI with the FIFO head when CNT>0, and with the last popped byte (0xFF after reset) when CNT=0.
REQ-017 SHALL, on a push while CNT=DEPTH, discard the byte, leave the FIFO unchanged, and set OVF until reset.
REQ-018 SHALL ignore a pop while CNT=0: no pointer change, no NMI state change.
REQ-019 SHALL, when a push and a pop occur in the same CLK48M cycle with 0<CNT<DEPTH, perform both and leave CNT unchanged.
REQ-020 SHALL, when a push and a pop coincide at CNT=DEPTH, perform the pop first, then the push, and leave OVF unchanged.
REQ-021 SHALL, when a push and a pop coincide at CNT=0, perform the push only; CNT becomes 1.
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL run the NMI FSM with states IDLE, ASSERT and GAP, where SNDNMI=1 only in ASSERT.
REQ-024 SHALL move IDLE->ASSERT on the first CLK48M cycle with CNT>0.
REQ-025 SHALL move ASSERT->GAP on a valid pop and load the gap counter with NMI_GAP.
REQ-026 SHALL decrement the gap counter in GAP on each SCPU_CE; at zero it goes to ASSERT if CNT>0, else to IDLE.
REQ-027 SHALL make SNDNMI a registered output, going high exactly one CLK48M cycle after the cycle in which CNT first becomes nonzero.

Reset
REQ-028 SHALL, on RESET, immediately clear both pointers, set CNT=0, OVF=0, SNDNMI=0, SCPU_DI=0xFF, FSM=IDLE, gap counter=0, and both edge-detect registers=0.
REQ-029 SHALL, on RESET asserted mid-handshake, drop queued bytes; the first push after release behaves as from power-up.

Structure
REQ-030 SHALL keep the FSM state encoding and the default DEPTH/NMI_GAP constants in the shared sys1_pkg package.
REQ-031 SHALL implement storage and pointers in one sub-module, cmd_fifo (push/pop/count/head), with edge detection and the NMI FSM in snd_cmd_latch.

Verification
REQ-032 SHALL verify a single write: SNDRQ pulse with CPUDO=0x85 -> CNT=1, SNDNMI high next cycle, SCPU_DI=0x85; a read pop -> CNT=0, SNDNMI low for 16 SCPU_CE ticks, then FSM=IDLE, SCPU_DI stays 0x85.
REQ-033 SHALL verify a burst: writes 0x01,0x02,0x03 back-to-back -> three pops return 0x01,0x02,0x03 in order, with NMI re-asserted after each 16-tick gap while CNT>0.
REQ-034 SHALL verify overflow: 5 writes 0x10..0x14 with no reads -> CNT=4, OVF=1, pops return 0x10..0x13, and 0x14 is lost.
REQ-035 SHALL verify a held strobe: SNDRQ high for 10 MCPU_CE ticks -> exactly one push.
REQ-036 SHALL verify simultaneous events: push and pop in the same cycle at CNT=2 -> CNT stays 2 with FIFO order preserved; at CNT=4 -> CNT stays 4 and OVF stays 0.
REQ-037 SHALL verify reset mid-operation: RESET during GAP with CNT=2 -> all outputs at reset values the same cycle, and the next write yields SCPU_DI equal to the new byte.

Source files
------------

// File: rtl/sys1_pkg.sv
// Shared constants and the NMI handshake state encoding for the sound command latch.
package sys1_pkg;

  localparam int unsigned DEFAULT_DEPTH   = 4;
  localparam int unsigned DEFAULT_NMI_GAP = 16;
  localparam int unsigned BYTE_W          = 8;

  // Value seen by the sound CPU before any command has ever been popped.
  localparam logic [BYTE_W-1:0] DI_RESET = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } nmi_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Command byte FIFO: storage, wrapping pointers, occupancy, registered head and sticky overflow.
module cmd_fifo
  import sys1_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic                     pop_ok_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               head,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_n;
  logic [AW-1:0] rptr_q, rptr_n;
  logic [CW-1:0] count_q, count_n;
  logic [CW-1:0] after_pop;
  logic [7:0]    head_q, head_n;
  logic          ovf_q, ovf_n;
  logic          full, empty, push_ok;

  // Resolve push/pop interaction: a pop always frees space before a push lands.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    pop_ok_c  = pop && !empty;
    push_ok   = push && (!full || pop_ok_c);
    ovf_n     = ovf_q || (push && full && !pop_ok_c);
    wptr_n    = push_ok  ? wptr_q + AW'(1) : wptr_q;
    rptr_n    = pop_ok_c ? rptr_q + AW'(1) : rptr_q;
    after_pop = count_q - CW'(pop_ok_c);
    count_n   = after_pop + CW'(push_ok);
    // Empty FIFO keeps showing the last popped byte, which is already in head_q.
    if (count_n == '0) begin
      head_n = head_q;
    end else if (push_ok && (after_pop == '0)) begin
      head_n = din;
    end else begin
      head_n = mem[rptr_n];
    end
  end

  // Pointer, count, head and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= DI_RESET;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_n;
      rptr_q  <= rptr_n;
      count_q <= count_n;
      head_q  <= head_n;
      ovf_q   <= ovf_n;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= din;
    end
  end

  assign count = count_q;
  assign head  = head_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/snd_cmd_latch.sv
// Main-CPU to sound-CPU command latch: strobe edge detection, command FIFO and NMI handshake.
module snd_cmd_latch
  import sys1_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned NMI_GAP = DEFAULT_NMI_GAP
) (
  input  logic                     CLK48M,
  input  logic                     RESET,
  input  logic                     MCPU_CE,
  input  logic                     SNDRQ,
  input  logic [7:0]               CPUDO,
  input  logic                     SCPU_CE,
  input  logic                     SCPU_RDCS,
  output logic [7:0]               SCPU_DI,
  output logic                     SNDNMI,
  output logic                     OVF,
  output logic [$clog2(DEPTH):0]   CNT
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned GW = (NMI_GAP > 0) ? $clog2(NMI_GAP + 1) : 1;

  logic          sndrq_q, rdcs_q;
  logic          push_req, pop_req, pop_ok;
  logic [CW-1:0] cnt;
  nmi_state_e    state_q, state_n;
  logic [GW-1:0] gap_q, gap_n;
  logic          nmi_q, nmi_n;

  // Sample each strobe only on its own CPU clock enable.
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      sndrq_q <= 1'b0;
      rdcs_q  <= 1'b0;
    end else begin
      if (MCPU_CE) begin
        sndrq_q <= SNDRQ;
      end
      if (SCPU_CE) begin
        rdcs_q <= SCPU_RDCS;
      end
    end
  end

  // Push on rising sampled write strobe, pop on falling sampled read strobe.
  assign push_req = MCPU_CE && SNDRQ && !sndrq_q;
  assign pop_req  = SCPU_CE && !SCPU_RDCS && rdcs_q;

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK48M),
    .rst      (RESET),
    .push     (push_req),
    .din      (CPUDO),
    .pop      (pop_req),
    .pop_ok_c (pop_ok),
    .count    (cnt),
    .head     (SCPU_DI),
    .ovf      (OVF)
  );

  // NMI next-state: raise while data waits, hold low for a gap after every accepted pop.
  always_comb begin
    state_n = state_q;
    gap_n   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (cnt != '0) begin
          state_n = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (pop_ok) begin
          state_n = ST_GAP;
          gap_n   = GW'(NMI_GAP);
        end
      end
      ST_GAP: begin
        if (SCPU_CE) begin
          if (gap_q <= GW'(1)) begin
            gap_n   = '0;
            state_n = (cnt != '0) ? ST_ASSERT : ST_IDLE;
          end else begin
            gap_n = gap_q - GW'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        gap_n   = '0;
      end
    endcase
    nmi_n = (state_n == ST_ASSERT);
  end

  // NMI state, gap counter and registered NMI output.
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      nmi_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      gap_q   <= gap_n;
      nmi_q   <= nmi_n;
    end
  end

  assign SNDNMI = nmi_q;
  assign CNT    = cnt;

endmodule

// File: tb/tb_snd_cmd_latch.sv
// Scoreboarded bench for snd_cmd_latch: directed scenarios plus randomized traffic.
module tb_snd_cmd_latch;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned NMI_GAP = 16;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic          CLK48M = 1'b0;
  logic          RESET;
  logic          MCPU_CE;
  logic          SNDRQ;
  logic [7:0]    CPUDO;
  logic          SCPU_CE;
  logic          SCPU_RDCS;
  logic [7:0]    SCPU_DI;
  logic          SNDNMI;
  logic          OVF;
  logic [CW-1:0] CNT;

  snd_cmd_latch #(
    .DEPTH   (DEPTH),
    .NMI_GAP (NMI_GAP)
  ) dut (
    .CLK48M    (CLK48M),
    .RESET     (RESET),
    .MCPU_CE   (MCPU_CE),
    .SNDRQ     (SNDRQ),
    .CPUDO     (CPUDO),
    .SCPU_CE   (SCPU_CE),
    .SCPU_RDCS (SCPU_RDCS),
    .SCPU_DI   (SCPU_DI),
    .SNDNMI    (SNDNMI),
    .OVF       (OVF),
    .CNT       (CNT)
  );

  always #5 CLK48M = ~CLK48M;

  typedef struct {
    logic [CW-1:0] cnt;
    logic          ovf;
    logic [7:0]    di;
    logic          nmi;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state: a plain byte queue plus NMI phase bookkeeping.
  logic [7:0] bytes_q[$];
  logic       m_ovf;
  logic [7:0] m_last;
  int         m_phase;     // 0 = no request, 1 = NMI raised, 2 = quiet gap
  int         m_gap_left;
  logic       m_prev_rq;
  logic       m_prev_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: each rising edge, derive the expected post-edge outputs and queue them.
  always @(posedge CLK48M) begin : model_p
    snap_t s;
    int    size_before;
    logic  wr_edge, rd_edge, took;
    if (RESET) begin
      bytes_q.delete();
      m_ovf      = 1'b0;
      m_last     = 8'hFF;
      m_phase    = 0;
      m_gap_left = 0;
      m_prev_rq  = 1'b0;
      m_prev_rd  = 1'b0;
    end else begin
      wr_edge = MCPU_CE && SNDRQ && !m_prev_rq;
      if (MCPU_CE) m_prev_rq = SNDRQ;
      rd_edge = SCPU_CE && !SCPU_RDCS && m_prev_rd;
      if (SCPU_CE) m_prev_rd = SCPU_RDCS;
      size_before = bytes_q.size();
      took = rd_edge && (size_before > 0);
      if (took) m_last = bytes_q.pop_front();
      if (wr_edge) begin
        if (bytes_q.size() < int'(DEPTH)) bytes_q.push_back(CPUDO);
        else m_ovf = 1'b1;
      end
      if (m_phase == 0) begin
        if (size_before > 0) m_phase = 1;
      end else if (m_phase == 1) begin
        if (took) begin
          m_phase    = 2;
          m_gap_left = int'(NMI_GAP);
        end
      end else if (SCPU_CE) begin
        m_gap_left = m_gap_left - 1;
        if (m_gap_left <= 0) m_phase = (size_before > 0) ? 1 : 0;
      end
    end
    s.cnt = CW'(bytes_q.size());
    s.ovf = m_ovf;
    s.di  = (bytes_q.size() > 0) ? bytes_q[0] : m_last;
    s.nmi = (m_phase == 1);
    exp_q.push_back(s);
  end

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  always @(negedge CLK48M) begin : monitor_p
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cnt",    32'(CNT),     32'(e.cnt));
      check("ovf",    32'(OVF),     32'(e.ovf));
      check("scpu_di", 32'(SCPU_DI), 32'(e.di));
      check("sndnmi", 32'(SNDNMI),  32'(e.nmi));
    end
  end

  task automatic step(input logic mce, input logic rq, input logic [7:0] d,
                      input logic sce, input logic rd);
    MCPU_CE   = mce;
    SNDRQ     = rq;
    CPUDO     = d;
    SCPU_CE   = sce;
    SCPU_RDCS = rd;
    @(negedge CLK48M);
  endtask

  task automatic write_byte(input logic [7:0] d);
    step(1'b1, 1'b1, d, 1'b1, 1'b0);
    step(1'b1, 1'b0, d, 1'b1, 1'b0);
  endtask

  task automatic read_byte();
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic expect_now(input string name, input int cnt, input logic ovf,
                            input logic [7:0] di, input logic nmi);
    #1;
    check({name, ".cnt"}, 32'(CNT),     32'(cnt));
    check({name, ".ovf"}, 32'(OVF),     32'(ovf));
    check({name, ".di"},  32'(SCPU_DI), 32'(di));
    check({name, ".nmi"}, 32'(SNDNMI),  32'(nmi));
  endtask

  // Assert reset between edges and confirm outputs clear before the next clock.
  task automatic do_reset();
    #2;
    RESET = 1'b1;
    expect_now("reset_async", 0, 1'b0, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    RESET = 1'b0;
  endtask

  initial begin
    logic rq, rd;
    RESET     = 1'b1;
    MCPU_CE   = 1'b0;
    SNDRQ     = 1'b0;
    CPUDO     = 8'h00;
    SCPU_CE   = 1'b0;
    SCPU_RDCS = 1'b0;
    repeat (3) @(negedge CLK48M);
    RESET = 1'b0;
    expect_now("reset_state", 0, 1'b0, 8'hFF, 1'b0);

    // Single write then read.
    write_byte(8'h85);
    expect_now("single_wr", 1, 1'b0, 8'h85, 1'b1);
    read_byte();
    expect_now("single_rd", 0, 1'b0, 8'h85, 1'b0);
    idle(20);
    expect_now("single_idle", 0, 1'b0, 8'h85, 1'b0);

    // Burst of three, drained with a full gap between reads.
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    expect_now("burst_full", 3, 1'b0, 8'h01, 1'b1);
    read_byte();
    idle(18);
    expect_now("burst_rd1", 2, 1'b0, 8'h02, 1'b1);
    read_byte();
    idle(18);
    expect_now("burst_rd2", 1, 1'b0, 8'h03, 1'b1);
    read_byte();
    idle(18);
    expect_now("burst_rd3", 0, 1'b0, 8'h03, 1'b0);

    // Overflow: fifth byte discarded.
    for (int i = 0; i < 5; i++) write_byte(8'(8'h10 + i));
    expect_now("ovf_full", 4, 1'b1, 8'h10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      read_byte();
      idle(18);
    end
    expect_now("ovf_drain", 0, 1'b1, 8'h13, 1'b0);
    do_reset();

    // Strobe held across ten main-CPU ticks pushes once.
    repeat (10) step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    expect_now("held_strobe", 1, 1'b0, 8'h77, 1'b1);
    read_byte();
    idle(18);

    // Simultaneous push and pop at CNT=2.
    write_byte(8'hA1);
    write_byte(8'hA2);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hA3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hA3, 1'b1, 1'b0);
    expect_now("simul_mid", 2, 1'b0, 8'hA2, 1'b0);
    idle(18);
    read_byte();
    idle(18);
    read_byte();
    idle(18);

    // Simultaneous push and pop at CNT=DEPTH.
    for (int i = 0; i < 4; i++) write_byte(8'(8'hB1 + i));
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hB5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hB5, 1'b1, 1'b0);
    expect_now("simul_full", 4, 1'b0, 8'hB2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(18);
      read_byte();
    end
    idle(18);
    expect_now("simul_drain", 0, 1'b0, 8'hB5, 1'b0);

    // Reset during the quiet gap with two bytes still queued.
    write_byte(8'hC1);
    write_byte(8'hC2);
    write_byte(8'hC3);
    read_byte();
    idle(3);
    expect_now("pre_reset_gap", 2, 1'b0, 8'hC2, 1'b0);
    do_reset();
    write_byte(8'h5A);
    expect_now("post_reset_wr", 1, 1'b0, 8'h5A, 1'b1);

    // Randomized traffic with alternating read pressure.
    rq = 1'b0;
    rd = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      int unsigned rd_odds;
      rd_odds = ((i / 500) % 2 == 0) ? 7 : 1;
      if ($urandom_range(0, 2) == 0) rq = ~rq;
      if ($urandom_range(0, rd_odds) == 0) rd = ~rd;
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        rq = 1'b0;
        rd = 1'b0;
      end
      step(1'($urandom_range(0, 1)), rq, 8'($urandom),
           1'($urandom_range(0, 2) == 0), rd);
    end

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
